// File: rtl/game_round_scheduler.sv
// Purpose : turn/round sequencer for the two-player game core, with per-turn timeout and round-boundary troop-growth sweep.
// Latency : turn switch 1 cycle after move_done/timeout; growth sweep is 2 cycles per cell (read, then write), 2*W^2 cycles per round.
// Backpres: none; busy is held high during the sweep so the game logic stays off the board, and move_done outside TURN is dropped.
//
// Ports:
//   clock, reset           : single clock, asynchronous active-low reset
//   start                  : pulse, begins a game from IDLE or OVER
//   move_done              : pulse, current player finished a move (TURN only)
//   game_over              : level/pulse, stops scheduling (any state but IDLE)
//   current_player         : NPC=0, RED=1, BLUE=2
//   round                  : current round, starts at 1, saturates at all-ones
//   turn_start / timeout   : one-cycle pulses at turn start / turn expiry
//   busy                   : high for the whole growth sweep
//   cell_h, cell_v         : sweep address (v inner, h outer)
//   cell_rd_en             : read request, data returns the following cycle
//   cell_owner/type/troop  : read data from the board
//   cell_wr_en/wr_troop    : troop write strobe and value (combinational)

module game_round_scheduler #(
  parameter int BORAD_WIDTH      = 10,
  parameter int LOG2_BORAD_WIDTH = 4,
  parameter int LOG2_MAX_TROOP   = 9,
  parameter int LOG2_MAX_ROUND   = 12,
  parameter int TURN_TICKS       = 50_000_000,
  parameter int GROWTH_PERIOD    = 25
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        move_done,
  input  logic                        game_over,
  output logic [2:0]                  current_player,
  output logic [LOG2_MAX_ROUND:0]     round,
  output logic                        turn_start,
  output logic                        timeout,
  output logic                        busy,
  output logic [LOG2_BORAD_WIDTH-1:0] cell_h,
  output logic [LOG2_BORAD_WIDTH-1:0] cell_v,
  output logic                        cell_rd_en,
  input  logic [2:0]                  cell_owner,
  input  logic [1:0]                  cell_type,
  input  logic [LOG2_MAX_TROOP-1:0]   cell_troop,
  output logic                        cell_wr_en,
  output logic [LOG2_MAX_TROOP-1:0]   cell_wr_troop
);

  localparam int TIMER_W = $clog2(TURN_TICKS);

  localparam logic [TIMER_W-1:0]          TIMER_LAST = TIMER_W'(TURN_TICKS - 1);
  localparam logic [TIMER_W-1:0]          TIMER_ONE  = TIMER_W'(1);
  localparam logic [LOG2_BORAD_WIDTH-1:0] ADDR_LAST  = LOG2_BORAD_WIDTH'(BORAD_WIDTH - 1);
  localparam logic [LOG2_BORAD_WIDTH-1:0] ADDR_ONE   = LOG2_BORAD_WIDTH'(1);
  localparam logic [LOG2_MAX_ROUND:0]     ROUND_ONE  = (LOG2_MAX_ROUND + 1)'(1);
  localparam logic [LOG2_MAX_TROOP:0]     TROOP_ONE  = (LOG2_MAX_TROOP + 1)'(1);

  localparam logic [2:0] PLAYER_NPC  = 3'd0;
  localparam logic [2:0] PLAYER_RED  = 3'd1;
  localparam logic [2:0] PLAYER_BLUE = 3'd2;

  localparam logic [1:0] TYPE_TERRITORY = 2'd0;
  localparam logic [1:0] TYPE_CROWN     = 2'd2;
  localparam logic [1:0] TYPE_CITY      = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TURN     = 3'd1,
    S_SWEEP_RD = 3'd2,
    S_SWEEP_WR = 3'd3,
    S_OVER     = 3'd4
  } state_t;

  // Registered state and outputs
  state_t                      r_state;
  logic [2:0]                  r_player;
  logic [LOG2_MAX_ROUND:0]     r_round;
  logic [TIMER_W-1:0]          r_timer;
  logic                        r_turn_start;
  logic                        r_busy;
  logic                        r_rd_en;
  logic [LOG2_BORAD_WIDTH-1:0] r_h;
  logic [LOG2_BORAD_WIDTH-1:0] r_v;

  // Next-state values
  state_t                      w_state_nxt;
  logic [2:0]                  w_player_nxt;
  logic [LOG2_MAX_ROUND:0]     w_round_nxt;
  logic [TIMER_W-1:0]          w_timer_nxt;
  logic                        w_turn_start_nxt;
  logic                        w_busy_nxt;
  logic                        w_rd_en_nxt;
  logic [LOG2_BORAD_WIDTH-1:0] w_h_nxt;
  logic [LOG2_BORAD_WIDTH-1:0] w_v_nxt;

  // Turn control
  logic w_timer_last;
  logic w_turn_end;

  // Growth decision for the cell currently presented on the read bus
  logic                    w_owned;
  logic                    w_fixed_grower;
  logic                    w_territory_due;
  logic                    w_grow;
  logic                    w_last_cell;
  logic [LOG2_MAX_TROOP:0] w_troop_inc;

  assign w_timer_last = (r_timer == TIMER_LAST);
  assign w_turn_end   = (r_state == S_TURN) && (move_done || w_timer_last);

  // move_done takes priority over an expiring timer, so timeout is gated by
  // the same-cycle move_done rather than registered ahead of it.
  assign timeout = (r_state == S_TURN) && w_timer_last && !move_done;

  assign w_owned         = (cell_owner != PLAYER_NPC);
  assign w_fixed_grower  = (cell_type == TYPE_CROWN) || (cell_type == TYPE_CITY);
  // r_round has already been advanced on sweep entry, so this is the new round.
  assign w_territory_due = (cell_type == TYPE_TERRITORY) &&
                           ((32'(r_round) % GROWTH_PERIOD) == 0);
  assign w_grow          = w_owned && (w_fixed_grower || w_territory_due);
  assign w_last_cell     = (r_h == ADDR_LAST) && (r_v == ADDR_LAST);

  // One extra bit catches the wrap at full scale; it then clamps to all-ones.
  assign w_troop_inc = {1'b0, cell_troop} + TROOP_ONE;

  always_comb begin
    cell_wr_en    = 1'b0;
    cell_wr_troop = '0;
    if ((r_state == S_SWEEP_WR) && w_grow) begin
      cell_wr_en    = 1'b1;
      cell_wr_troop = w_troop_inc[LOG2_MAX_TROOP] ? '1 : w_troop_inc[LOG2_MAX_TROOP-1:0];
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_player_nxt     = r_player;
    w_round_nxt      = r_round;
    w_timer_nxt      = r_timer;
    w_turn_start_nxt = 1'b0;
    w_busy_nxt       = r_busy;
    w_rd_en_nxt      = 1'b0;
    w_h_nxt          = r_h;
    w_v_nxt          = r_v;

    case (r_state)
      S_IDLE, S_OVER: begin
        if (start) begin
          w_state_nxt      = S_TURN;
          w_player_nxt     = PLAYER_RED;
          w_round_nxt      = ROUND_ONE;
          w_timer_nxt      = '0;
          w_turn_start_nxt = 1'b1;
          w_busy_nxt       = 1'b0;
        end
      end

      S_TURN: begin
        if (w_turn_end) begin
          w_timer_nxt = '0;
          if (r_player == PLAYER_RED) begin
            w_player_nxt     = PLAYER_BLUE;
            w_turn_start_nxt = 1'b1;
          end else begin
            // BLUE closes the round: advance it and sweep the board.
            w_state_nxt = S_SWEEP_RD;
            w_round_nxt = (r_round == '1) ? r_round : r_round + ROUND_ONE;
            w_busy_nxt  = 1'b1;
            w_rd_en_nxt = 1'b1;
            w_h_nxt     = '0;
            w_v_nxt     = '0;
          end
        end else begin
          w_timer_nxt = r_timer + TIMER_ONE;
        end
      end

      S_SWEEP_RD: begin
        w_state_nxt = S_SWEEP_WR;
      end

      S_SWEEP_WR: begin
        if (w_last_cell) begin
          w_state_nxt      = S_TURN;
          w_player_nxt     = PLAYER_RED;
          w_timer_nxt      = '0;
          w_turn_start_nxt = 1'b1;
          w_busy_nxt       = 1'b0;
        end else begin
          w_state_nxt = S_SWEEP_RD;
          w_rd_en_nxt = 1'b1;
          if (r_v == ADDR_LAST) begin
            w_v_nxt = '0;
            w_h_nxt = r_h + ADDR_ONE;
          end else begin
            w_v_nxt = r_v + ADDR_ONE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // game_over overrides every transition above; player, round and address
    // freeze where they were so the final position stays visible.
    if (game_over && (r_state != S_IDLE)) begin
      w_state_nxt      = S_OVER;
      w_player_nxt     = r_player;
      w_round_nxt      = r_round;
      w_timer_nxt      = '0;
      w_turn_start_nxt = 1'b0;
      w_busy_nxt       = 1'b0;
      w_rd_en_nxt      = 1'b0;
      w_h_nxt          = r_h;
      w_v_nxt          = r_v;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_player     <= PLAYER_RED;
      r_round      <= ROUND_ONE;
      r_timer      <= '0;
      r_turn_start <= 1'b0;
      r_busy       <= 1'b0;
      r_rd_en      <= 1'b0;
      r_h          <= '0;
      r_v          <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_player     <= w_player_nxt;
      r_round      <= w_round_nxt;
      r_timer      <= w_timer_nxt;
      r_turn_start <= w_turn_start_nxt;
      r_busy       <= w_busy_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_h          <= w_h_nxt;
      r_v          <= w_v_nxt;
    end
  end

  assign current_player = r_player;
  assign round          = r_round;
  assign turn_start     = r_turn_start;
  assign busy           = r_busy;
  assign cell_rd_en     = r_rd_en;
  assign cell_h         = r_h;
  assign cell_v         = r_v;

endmodule

// File: tb/tb_game_round_scheduler.sv
// Purpose : directed self-checking bench for game_round_scheduler with a small board memory model.
// Latency : board model returns read data one cycle after cell_rd_en and commits writes on the clock edge.
// Backpres: none; stimulus is a linear sequence of directed steps.

module tb_game_round_scheduler;

  localparam int W  = 10;
  localparam int AW = 4;
  localparam int TW = 9;
  localparam int RW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          move_done = 1'b0;
  logic          game_over = 1'b0;
  logic [2:0]    current_player;
  logic [RW:0]   round;
  logic          turn_start;
  logic          timeout;
  logic          busy;
  logic [AW-1:0] cell_h;
  logic [AW-1:0] cell_v;
  logic          cell_rd_en;
  logic [2:0]    cell_owner = 3'd0;
  logic [1:0]    cell_type = 2'd0;
  logic [TW-1:0] cell_troop = '0;
  logic          cell_wr_en;
  logic [TW-1:0] cell_wr_troop;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  game_round_scheduler #(
    .BORAD_WIDTH     (W),
    .LOG2_BORAD_WIDTH(AW),
    .LOG2_MAX_TROOP  (TW),
    .LOG2_MAX_ROUND  (RW),
    .TURN_TICKS      (16),
    .GROWTH_PERIOD   (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .move_done     (move_done),
    .game_over     (game_over),
    .current_player(current_player),
    .round         (round),
    .turn_start    (turn_start),
    .timeout       (timeout),
    .busy          (busy),
    .cell_h        (cell_h),
    .cell_v        (cell_v),
    .cell_rd_en    (cell_rd_en),
    .cell_owner    (cell_owner),
    .cell_type     (cell_type),
    .cell_troop    (cell_troop),
    .cell_wr_en    (cell_wr_en),
    .cell_wr_troop (cell_wr_troop)
  );

  always #5 clock = ~clock;

  // Board model: owner/type/troop per cell, plus read/write counters.
  logic [2:0]    m_owner [16][16];
  logic [1:0]    m_type  [16][16];
  logic [TW-1:0] m_troop [16][16];
  int            m_wr_per[16][16];
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  logic          board_loaded = 1'b0;

  always @(posedge clock) begin
    if (!board_loaded) begin
      for (int h = 0; h < 16; h++) begin
        for (int v = 0; v < 16; v++) begin
          m_owner[h][v]  <= 3'd0;
          m_type[h][v]   <= 2'd0;
          m_troop[h][v]  <= '0;
          m_wr_per[h][v] <= 0;
        end
      end
      m_owner[2][4] <= 3'd1; m_type[2][4] <= 2'd2; m_troop[2][4] <= 9'h057; // RED CROWN
      m_owner[5][7] <= 3'd1; m_type[5][7] <= 2'd3; m_troop[5][7] <= 9'h043; // RED CITY
      m_owner[0][0] <= 3'd2; m_type[0][0] <= 2'd0; m_troop[0][0] <= 9'd5;   // BLUE TERRITORY
      m_owner[9][9] <= 3'd2; m_type[9][9] <= 2'd3; m_troop[9][9] <= 9'd511; // BLUE CITY, full
      m_owner[4][4] <= 3'd1; m_type[4][4] <= 2'd1; m_troop[4][4] <= 9'd10;  // RED MOUNTAIN
      m_owner[1][1] <= 3'd0; m_type[1][1] <= 2'd3; m_troop[1][1] <= 9'd7;   // NPC CITY
      board_loaded <= 1'b1;
    end else begin
      if (cell_rd_en) begin
        cell_owner <= m_owner[cell_h][cell_v];
        cell_type  <= m_type[cell_h][cell_v];
        cell_troop <= m_troop[cell_h][cell_v];
        rd_cnt     <= rd_cnt + 1;
      end
      if (cell_wr_en) begin
        m_troop[cell_h][cell_v]  <= cell_wr_troop;
        m_wr_per[cell_h][cell_v] <= m_wr_per[cell_h][cell_v] + 1;
        wr_cnt                   <= wr_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts consecutive busy cycles starting with the current one; bounded.
  task automatic wait_sweep(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 400) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    int n;
    int r0;
    int w0;

    // Reset state
    tick();
    tick();
    check("rst_player", current_player, 1);
    check("rst_round", round, 1);
    check("rst_turn_start", turn_start, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", cell_rd_en, 0);
    check("rst_wr_en", cell_wr_en, 0);
    check("rst_addr", {cell_h, cell_v}, 0);
    check("rst_wr_troop", cell_wr_troop, 0);
    reset = 1'b1;

    // start -> first TURN cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_turn_start", turn_start, 1);
    check("start_player", current_player, 1);
    check("start_round", round, 1);
    check("start_busy", busy, 0);
    check("start_rd_en", cell_rd_en, 0);
    check("start_timeout", timeout, 0);
    tick();
    check("turn_start_pulse", turn_start, 0);
    tick();
    tick();

    // RED move -> BLUE
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    check("red_move_player", current_player, 2);
    check("red_move_turn_start", turn_start, 1);

    // start during TURN is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_player", current_player, 2);
    check("start_ignored_turn_start", turn_start, 0);

    // BLUE move -> round-2 sweep
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    check("sweep2_busy", busy, 1);
    check("sweep2_rd_en", cell_rd_en, 1);
    check("sweep2_round", round, 2);
    check("sweep2_player", current_player, 2);
    check("sweep2_addr", {cell_h, cell_v}, 0);
    wait_sweep(n);
    check("sweep2_busy_cycles", n, 200);
    check("sweep2_end_player", current_player, 1);
    check("sweep2_end_turn_start", turn_start, 1);
    check("sweep2_reads", rd_cnt, 100);
    check("sweep2_writes", wr_cnt, 4);
    check("sweep2_crown", m_troop[2][4], 9'h058);
    check("sweep2_city", m_troop[5][7], 9'h044);
    check("sweep2_territory", m_troop[0][0], 6);
    check("sweep2_full_city", m_troop[9][9], 511);
    check("sweep2_full_city_written", m_wr_per[9][9], 1);
    check("sweep2_mountain_unwritten", m_wr_per[4][4], 0);
    check("sweep2_npc_unwritten", m_wr_per[1][1], 0);

    // RED turn times out on its 16th cycle
    for (int i = 0; i < 14; i++) tick();
    check("pre_timeout", timeout, 0);
    tick();
    check("timeout_pulse", timeout, 1);
    check("timeout_player", current_player, 1);
    tick();
    check("post_timeout_player", current_player, 2);
    check("post_timeout_turn_start", turn_start, 1);
    check("post_timeout_timeout", timeout, 0);

    // BLUE move coincides with timeout: move wins
    for (int i = 0; i < 15; i++) tick();
    move_done = 1'b1;
    #1;
    check("coincide_timeout", timeout, 0);
    tick();
    move_done = 1'b0;
    check("coincide_busy", busy, 1);
    check("coincide_round", round, 3);
    wait_sweep(n);
    check("sweep3_busy_cycles", n, 200);
    check("sweep3_territory_held", m_troop[0][0], 6);
    check("sweep3_territory_writes", m_wr_per[0][0], 1);
    check("sweep3_crown", m_troop[2][4], 9'h059);
    check("sweep3_full_city_writes", m_wr_per[9][9], 2);
    check("sweep3_writes", wr_cnt, 7);

    // Round-4 sweep interrupted by game_over on sweep cycle 50
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    check("sweep4_round", round, 4);
    r0 = rd_cnt;
    w0 = wr_cnt;
    for (int i = 0; i < 49; i++) tick();
    check("sweep4_c50_wr_en", cell_wr_en, 1);
    check("sweep4_c50_wr_troop", cell_wr_troop, 9'h05A);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check("over_busy", busy, 0);
    check("over_rd_en", cell_rd_en, 0);
    check("over_wr_en", cell_wr_en, 0);
    check("over_player", current_player, 2);
    check("over_round", round, 4);
    for (int i = 0; i < 5; i++) tick();
    check("over_reads", rd_cnt - r0, 25);
    check("over_writes", wr_cnt - w0, 2);
    check("over_crown", m_troop[2][4], 9'h05A);
    check("over_territory", m_troop[0][0], 7);
    check("over_city_untouched", m_troop[5][7], 9'h045);

    // Restart from OVER
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_player", current_player, 1);
    check("restart_round", round, 1);
    check("restart_turn_start", turn_start, 1);

    // Asynchronous reset in the middle of a sweep write
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    tick();
    check("midsweep_wr_en", cell_wr_en, 1);
    check("midsweep_wr_troop", cell_wr_troop, 8);
    reset = 1'b0;
    #2;
    check("async_rst_wr_en", cell_wr_en, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_rd_en", cell_rd_en, 0);
    check("async_rst_player", current_player, 1);
    check("async_rst_wr_troop", cell_wr_troop, 0);
    tick();
    reset = 1'b1;

    // move_done in IDLE does nothing
    move_done = 1'b1;
    tick();
    tick();
    move_done = 1'b0;
    check("idle_move_player", current_player, 1);
    check("idle_move_turn_start", turn_start, 0);
    check("idle_move_busy", busy, 0);
    check("idle_move_round", round, 1);
    check("idle_move_board", m_troop[0][0], 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
